// File: rtl/reg_file_reader_if.sv
// Valid/ready word stream from the register file read sequencer to its consumer.
interface reg_file_reader_if #(
  parameter int unsigned DW = 32
);
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/reg_file_reader.sv
// Read-side sequencer: sweeps rAddr over [first_addr..last_addr] (wrapping),
// captures each combinational rData word and streams it out with valid/ready.
module reg_file_reader #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] rAddr,
  input  logic [DW-1:0] rData,
  reg_file_reader_if.master outIf,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state, stateNext;
  logic [AW-1:0] addrQ, addrNext;
  logic [AW-1:0] lastQ, lastNext;
  logic [DW-1:0] dataQ, dataNext;
  logic          validQ, validNext;
  logic          lastFlagQ, lastFlagNext;
  logic          doneQ, doneNext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addrQ     <= '0;
      lastQ     <= '0;
      dataQ     <= '0;
      validQ    <= 1'b0;
      lastFlagQ <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      state     <= stateNext;
      addrQ     <= addrNext;
      lastQ     <= lastNext;
      dataQ     <= dataNext;
      validQ    <= validNext;
      lastFlagQ <= lastFlagNext;
      doneQ     <= doneNext;
    end
  end

  always_comb begin
    stateNext    = state;
    addrNext     = addrQ;
    lastNext     = lastQ;
    dataNext     = dataQ;
    validNext    = validQ;
    lastFlagNext = lastFlagQ;
    doneNext     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          addrNext  = first_addr;
          lastNext  = last_addr;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          validNext    = 1'b0;
          lastFlagNext = 1'b0;
          stateNext    = IDLE;
        end else begin
          dataNext     = rData;
          validNext    = 1'b1;
          lastFlagNext = (addrQ == lastQ);
          stateNext    = SEND;
        end
      end
      SEND: begin
        // abort outranks a same-cycle handshake: the word is treated as not taken
        if (abort) begin
          validNext    = 1'b0;
          lastFlagNext = 1'b0;
          stateNext    = IDLE;
        end else if (outIf.out_ready) begin
          validNext = 1'b0;
          if (lastFlagQ) begin
            lastFlagNext = 1'b0;
            doneNext     = 1'b1;
            stateNext    = IDLE;
          end else begin
            addrNext  = AW'(addrQ + 1'b1);
            stateNext = LOAD;
          end
        end
      end
      default: begin
        validNext    = 1'b0;
        lastFlagNext = 1'b0;
        stateNext    = IDLE;
      end
    endcase
  end

  assign rAddr           = addrQ;
  assign outIf.out_data  = dataQ;
  assign outIf.out_valid = validQ;
  assign outIf.out_last  = lastFlagQ;
  assign busy            = (state != IDLE);
  assign done            = doneQ;

endmodule

// File: tb/tb_reg_file_reader.sv
// Directed bench for reg_file_reader with a behavioural 8x32 register file.
module tb_reg_file_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [2:0]  first_addr;
  logic [2:0]  last_addr;
  logic [2:0]  rAddr;
  logic [31:0] rData;
  logic        busy;
  logic        done;
  logic [31:0] mem [8];

  int unsigned testsRun;
  int unsigned testsFailed;

  reg_file_reader_if #(.DW(32)) outIf ();

  reg_file_reader #(.AW(3), .DW(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rAddr      (rAddr),
    .rData      (rData),
    .outIf      (outIf),
    .busy       (busy),
    .done       (done)
  );

  always_comb rData = mem[rAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, ".busy"},  32'(busy), 32'd0);
    check({tag, ".valid"}, 32'(outIf.out_valid), 32'd0);
    check({tag, ".last"},  32'(outIf.out_last), 32'd0);
  endtask

  // Leaves the DUT in LOAD with the new range latched.
  task automatic startSweep(input logic [2:0] f, input logic [2:0] l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Entered in LOAD with out_ready=1; walks LOAD -> SEND -> handshake.
  task automatic expectWord(input string tag, input logic [2:0] a, input logic [31:0] d, input logic l);
    check({tag, ".rAddr"}, 32'(rAddr), 32'(a));
    check({tag, ".loadValid"}, 32'(outIf.out_valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, ".valid"}, 32'(outIf.out_valid), 32'd1);
    check({tag, ".data"}, outIf.out_data, d);
    check({tag, ".last"}, 32'(outIf.out_last), 32'(l));
    check({tag, ".doneEarly"}, 32'(done), 32'd0);
    tick();
    check({tag, ".validDrop"}, 32'(outIf.out_valid), 32'd0);
    check({tag, ".done"}, 32'(done), 32'(l));
    if (l) begin
      checkIdle({tag, ".end"});
      tick();
      check({tag, ".donePulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    testsRun        = 0;
    testsFailed     = 0;
    reset_n         = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    first_addr      = '0;
    last_addr       = '0;
    outIf.out_ready = 1'b1;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'hff00_ff00;
    mem[2] = 32'hff00_ff00;
    mem[3] = 32'h00ff_00ff;
    mem[4] = 32'h4444_4444;
    mem[5] = 32'h5555_5555;
    mem[6] = 32'h6666_6666;
    mem[7] = 32'h7777_7777;

    #12;
    check("rst.rAddr", 32'(rAddr), 32'd0);
    check("rst.data", outIf.out_data, 32'd0);
    check("rst.done", 32'(done), 32'd0);
    checkIdle("rst");
    reset_n = 1'b1;
    tick();
    checkIdle("rst.release");

    // 1: four-word sweep 0..3
    startSweep(3'd0, 3'd3);
    expectWord("t1.w0", 3'd0, 32'h1111_1111, 1'b0);
    expectWord("t1.w1", 3'd1, 32'hff00_ff00, 1'b0);
    expectWord("t1.w2", 3'd2, 32'hff00_ff00, 1'b0);
    expectWord("t1.w3", 3'd3, 32'h00ff_00ff, 1'b1);
    check("t1.rAddrHold", 32'(rAddr), 32'd3);

    // 2: single word
    startSweep(3'd2, 3'd2);
    expectWord("t2.w0", 3'd2, 32'hff00_ff00, 1'b1);

    // 3: wrap 6,7,0
    mem[6] = 32'h0000_000A;
    mem[7] = 32'h0000_000B;
    mem[0] = 32'h0000_000C;
    startSweep(3'd6, 3'd0);
    expectWord("t3.w0", 3'd6, 32'h0000_000A, 1'b0);
    expectWord("t3.w1", 3'd7, 32'h0000_000B, 1'b0);
    expectWord("t3.w2", 3'd0, 32'h0000_000C, 1'b1);

    // 4: backpressure on the first of two words
    mem[0] = 32'h1111_1111;
    outIf.out_ready = 1'b0;
    startSweep(3'd0, 3'd1);
    tick();
    check("t4.valid", 32'(outIf.out_valid), 32'd1);
    check("t4.data", outIf.out_data, 32'h1111_1111);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4.holdValid", 32'(outIf.out_valid), 32'd1);
      check("t4.holdData", outIf.out_data, 32'h1111_1111);
      check("t4.holdAddr", 32'(rAddr), 32'd0);
    end
    outIf.out_ready = 1'b1;
    tick();
    check("t4.accValid", 32'(outIf.out_valid), 32'd0);
    expectWord("t4.w1", 3'd1, 32'hff00_ff00, 1'b1);

    // 5: start while busy is ignored, then abort in SEND
    startSweep(3'd0, 3'd3);
    first_addr = 3'd5;
    last_addr  = 3'd5;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("t5.data0", outIf.out_data, 32'h1111_1111);
    check("t5.last0", 32'(outIf.out_last), 32'd0);
    tick();
    check("t5.rAddr1", 32'(rAddr), 32'd1);
    tick();
    check("t5.data1", outIf.out_data, 32'hff00_ff00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkIdle("t5.abort");
    check("t5.abortDone", 32'(done), 32'd0);
    check("t5.abortAddr", 32'(rAddr), 32'd1);
    tick();
    check("t5.noDone", 32'(done), 32'd0);
    abort = 1'b1;
    startSweep(3'd3, 3'd3);
    abort = 1'b0;
    checkIdle("t5.abortStart");
    startSweep(3'd3, 3'd3);
    expectWord("t5.fresh", 3'd3, 32'h00ff_00ff, 1'b1);

    // 6: asynchronous reset in SEND
    startSweep(3'd0, 3'd3);
    outIf.out_ready = 1'b0;
    tick();
    check("t6.sendValid", 32'(outIf.out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkIdle("t6.rst");
    check("t6.rstData", outIf.out_data, 32'd0);
    check("t6.rstAddr", 32'(rAddr), 32'd0);
    check("t6.rstDone", 32'(done), 32'd0);
    #4;
    reset_n = 1'b1;
    outIf.out_ready = 1'b1;
    tick();
    tick();
    checkIdle("t6.stayIdle");
    check("t6.noDone", 32'(done), 32'd0);
    startSweep(3'd1, 3'd1);
    expectWord("t6.fresh", 3'd1, 32'hff00_ff00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
